// File: rtl/rob_commit_unit_if.sv
// Signal bundle between the reorder buffer and Decoder / RS / LSB / regfile.
// Entry-id width follows the `ROB_SIZE_WIDTH config macro (default 3).
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

interface rob_commit_unit_if #(
  parameter int unsigned ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH
) ();
  logic                      rdy;
  logic                      issue_valid;
  logic [1:0]                issue_kind;
  logic [4:0]                issue_rd;
  logic                      issue_pred_taken;
  logic [31:0]               issue_alt_pc;
  logic                      rob_full;
  logic [ROB_SIZE_WIDTH-1:0] tail_id;
  logic [ROB_SIZE_WIDTH-1:0] query_id1;
  logic [ROB_SIZE_WIDTH-1:0] query_id2;
  logic                      query_ready1;
  logic                      query_ready2;
  logic [31:0]               query_value1;
  logic [31:0]               query_value2;
  logic                      rs_ready;
  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id;
  logic [31:0]               rs_value;
  logic                      lsb_ready;
  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id;
  logic [31:0]               lsb_value;
  logic                      commit_valid;
  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
  logic [4:0]                commit_rd;
  logic [31:0]               commit_value;
  logic                      commit_store;
  logic                      rob_clear;
  logic [31:0]               clear_pc;
  logic [31:0]               perf_commits;
  logic [31:0]               perf_mispredicts;

  modport master (
    output rdy, issue_valid, issue_kind, issue_rd, issue_pred_taken, issue_alt_pc,
    output query_id1, query_id2, rs_ready, rs_rob_id, rs_value,
    output lsb_ready, lsb_rob_id, lsb_value,
    input  rob_full, tail_id, query_ready1, query_ready2, query_value1, query_value2,
    input  commit_valid, commit_rob_id, commit_rd, commit_value, commit_store,
    input  rob_clear, clear_pc, perf_commits, perf_mispredicts
  );

  modport slave (
    input  rdy, issue_valid, issue_kind, issue_rd, issue_pred_taken, issue_alt_pc,
    input  query_id1, query_id2, rs_ready, rs_rob_id, rs_value,
    input  lsb_ready, lsb_rob_id, lsb_value,
    output rob_full, tail_id, query_ready1, query_ready2, query_value1, query_value2,
    output commit_valid, commit_rob_id, commit_rd, commit_value, commit_store,
    output rob_clear, clear_pc, perf_commits, perf_mispredicts
  );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order commit with flush on
// branch mispredict. Define ROB_PERF_CNT_EN to enable the commit/mispredict counters.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

module rob_commit_unit #(
  parameter int unsigned ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH
) (
  input logic              clk,
  input logic              rst,
  rob_commit_unit_if.slave io_bus
);
  localparam int unsigned RobSize = 1 << ROB_SIZE_WIDTH;
  localparam logic [1:0] KindReg    = 2'd0;
  localparam logic [1:0] KindBranch = 2'd1;
  localparam logic [1:0] KindStore  = 2'd2;
  localparam logic [1:0] KindNop    = 2'd3;

  typedef logic [ROB_SIZE_WIDTH-1:0] id_t;

  id_t                 r_head;
  id_t                 r_tail;
  logic [ROB_SIZE_WIDTH:0] r_count;
  logic [RobSize-1:0]  r_busy;
  logic [RobSize-1:0]  r_ready;
  logic [1:0]          r_kind   [RobSize];
  logic [4:0]          r_rd     [RobSize];
  logic [31:0]         r_value  [RobSize];
  logic                r_pred   [RobSize];
  logic [31:0]         r_alt_pc [RobSize];

  logic                r_commit_valid;
  id_t                 r_commit_rob_id;
  logic [4:0]          r_commit_rd;
  logic [31:0]         r_commit_value;
  logic                r_commit_store;
  logic                r_rob_clear;
  logic [31:0]         r_clear_pc;

  logic                w_full;
  logic                w_issue;
  logic                w_commit;
  logic                w_mispredict;
  logic                w_flush;

  assign w_full       = (r_count == (ROB_SIZE_WIDTH + 1)'(RobSize));
  assign w_issue      = io_bus.issue_valid && !w_full;
  assign w_commit     = r_busy[r_head] && r_ready[r_head];
  assign w_mispredict = w_commit && (r_kind[r_head] == KindBranch) &&
                        (r_value[r_head][0] != r_pred[r_head]);
  // A flush cycle behaves like reset for everything except the perf counters.
  assign w_flush      = io_bus.rdy && r_rob_clear;

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_busy          <= '0;
      r_ready         <= '0;
      r_commit_valid  <= 1'b0;
      r_commit_rob_id <= '0;
      r_commit_rd     <= '0;
      r_commit_value  <= '0;
      r_commit_store  <= 1'b0;
      r_rob_clear     <= 1'b0;
      r_clear_pc      <= '0;
    end else if (io_bus.rdy) begin
      for (int i = 0; i < RobSize; i++) begin
        if (io_bus.rs_ready && io_bus.rs_rob_id == id_t'(i) && r_busy[i]) begin
          r_value[i] <= io_bus.rs_value;
          r_ready[i] <= 1'b1;
        end
        if (io_bus.lsb_ready && io_bus.lsb_rob_id == id_t'(i) && r_busy[i]) begin
          r_value[i] <= io_bus.lsb_value;
          r_ready[i] <= 1'b1;
        end
      end

      if (w_issue) begin
        r_busy[r_tail]   <= 1'b1;
        r_ready[r_tail]  <= (io_bus.issue_kind == KindNop);
        r_kind[r_tail]   <= io_bus.issue_kind;
        r_rd[r_tail]     <= io_bus.issue_rd;
        r_pred[r_tail]   <= io_bus.issue_pred_taken;
        r_alt_pc[r_tail] <= io_bus.issue_alt_pc;
        r_tail           <= r_tail + 1'b1;
      end

      // Later assignments win, so a retiring head drops ready even if a broadcast hit it.
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_commit_rob_id <= r_head;
        r_commit_rd     <= (r_kind[r_head] == KindReg) ? r_rd[r_head] : 5'd0;
        r_commit_value  <= r_value[r_head];
      end

      case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_commit_valid <= w_commit;
      r_commit_store <= w_commit && (r_kind[r_head] == KindStore);
      r_rob_clear    <= w_mispredict;
      if (w_mispredict) begin
        r_clear_pc <= r_alt_pc[r_head];
      end
    end
  end

  // Operand lookup: a same-cycle broadcast overrides the stored entry.
  always_comb begin
    io_bus.query_ready1 = r_ready[io_bus.query_id1];
    io_bus.query_value1 = r_value[io_bus.query_id1];
    io_bus.query_ready2 = r_ready[io_bus.query_id2];
    io_bus.query_value2 = r_value[io_bus.query_id2];
    if (io_bus.lsb_ready && io_bus.lsb_rob_id == io_bus.query_id1) begin
      io_bus.query_ready1 = 1'b1;
      io_bus.query_value1 = io_bus.lsb_value;
    end
    if (io_bus.rs_ready && io_bus.rs_rob_id == io_bus.query_id1) begin
      io_bus.query_ready1 = 1'b1;
      io_bus.query_value1 = io_bus.rs_value;
    end
    if (io_bus.lsb_ready && io_bus.lsb_rob_id == io_bus.query_id2) begin
      io_bus.query_ready2 = 1'b1;
      io_bus.query_value2 = io_bus.lsb_value;
    end
    if (io_bus.rs_ready && io_bus.rs_rob_id == io_bus.query_id2) begin
      io_bus.query_ready2 = 1'b1;
      io_bus.query_value2 = io_bus.rs_value;
    end
  end

  assign io_bus.rob_full      = w_full;
  assign io_bus.tail_id       = r_tail;
  assign io_bus.commit_valid  = r_commit_valid;
  assign io_bus.commit_rob_id = r_commit_rob_id;
  assign io_bus.commit_rd     = r_commit_rd;
  assign io_bus.commit_value  = r_commit_value;
  assign io_bus.commit_store  = r_commit_store;
  assign io_bus.rob_clear     = r_rob_clear;
  assign io_bus.clear_pc      = r_clear_pc;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commits;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_commits     <= '0;
      r_perf_mispredicts <= '0;
    end else if (io_bus.rdy && !r_rob_clear) begin
      if (w_commit) begin
        r_perf_commits <= r_perf_commits + 32'd1;
      end
      if (w_mispredict) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign io_bus.perf_commits     = r_perf_commits;
  assign io_bus.perf_mispredicts = r_perf_mispredicts;
`else
  assign io_bus.perf_commits     = 32'd0;
  assign io_bus.perf_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: vector table of single transactions plus
// hand-written fill/flush/stall/reset sequences, commits checked against a scoreboard.
module tb_rob_commit_unit;
  localparam int unsigned W = 3;
  localparam logic [1:0] KReg = 2'd0, KBr = 2'd1, KSt = 2'd2, KNop = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_commit_unit_if #(.ROB_SIZE_WIDTH(W)) bus ();
  rob_commit_unit #(.ROB_SIZE_WIDTH(W)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  typedef struct {
    logic [W-1:0] id;
    logic [4:0]   rd;
    logic [31:0]  value;
    logic         chk_value;
    logic         store;
    logic         clear;
    logic [31:0]  clear_pc;
  } exp_t;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt_pc;
    logic [31:0] wb;
    logic        via_lsb;
    logic [4:0]  exp_rd;
    logic        exp_store;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[7];
  int           n_vec = 0;
  int           n_err = 0;
  int           n_commits = 0;
  int           n_misp = 0;
  logic [W-1:0] exp_tail = '0;
  logic         rdy_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_commit(input logic [W-1:0] id, input logic [4:0] rd,
                                        input logic [31:0] v, input logic chk, input logic st,
                                        input logic clr, input logic [31:0] pc);
    exp_t e;
    e.id = id; e.rd = rd; e.value = v; e.chk_value = chk;
    e.store = st; e.clear = clr; e.clear_pc = pc;
    sb.push_back(e);
  endfunction

  task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic pred,
                       input logic [31:0] alt);
    bus.issue_valid = 1'b1; bus.issue_kind = kind; bus.issue_rd = rd;
    bus.issue_pred_taken = pred; bus.issue_alt_pc = alt;
    tick();
    bus.issue_valid = 1'b0;
    exp_tail = exp_tail + 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_perf(input string name);
`ifdef ROB_PERF_CNT_EN
    check({name, "_commits"}, bus.perf_commits, 32'(n_commits));
    check({name, "_mispredicts"}, bus.perf_mispredicts, 32'(n_misp));
`else
    check({name, "_commits"}, bus.perf_commits, 32'd0);
    check({name, "_mispredicts"}, bus.perf_mispredicts, 32'd0);
`endif
  endtask

  // A commit is new only if rdy was high on the edge that produced it.
  always @(posedge clk) rdy_q <= bus.rdy;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      n_commits = 0;
      n_misp = 0;
    end else if (rdy_q && bus.commit_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 32'(bus.commit_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        n_commits++;
        if (e.clear) n_misp++;
        check("commit_rob_id", 32'(bus.commit_rob_id), 32'(e.id));
        check("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
        check("commit_store", 32'(bus.commit_store), 32'(e.store));
        check("rob_clear", 32'(bus.rob_clear), 32'(e.clear));
        if (e.clear) check("clear_pc", bus.clear_pc, e.clear_pc);
        if (e.chk_value) check("commit_value", bus.commit_value, e.value);
      end
    end
  end

  function automatic logic [31:0] fill_val(input int i);
    if (i == 0) return 32'h11;
    if (i == 1) return 32'h55;
    if (i == 3) return 32'hDEAD;
    return 32'h100 + 32'(i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{KReg, 5'd5,  1'b0, 32'h0,   32'h1234,      1'b0, 5'd5,  1'b0};
    vecs[1] = '{KReg, 5'd0,  1'b0, 32'h0,   32'h77,        1'b0, 5'd0,  1'b0};
    vecs[2] = '{KBr,  5'd9,  1'b1, 32'h200, 32'h1,         1'b0, 5'd0,  1'b0};
    vecs[3] = '{KBr,  5'd9,  1'b0, 32'h300, 32'h0,         1'b0, 5'd0,  1'b0};
    vecs[4] = '{KSt,  5'd7,  1'b0, 32'h0,   32'hCAFE,      1'b1, 5'd0,  1'b1};
    vecs[5] = '{KReg, 5'd31, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b1, 5'd31, 1'b0};
    vecs[6] = '{KNop, 5'd3,  1'b0, 32'h0,   32'h0,         1'b0, 5'd0,  1'b0};

    rst = 1'b1;
    bus.rdy = 1'b1; bus.issue_valid = 1'b0; bus.issue_kind = KReg; bus.issue_rd = '0;
    bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = '0; bus.query_id1 = '0; bus.query_id2 = '0;
    bus.rs_ready = 1'b0; bus.rs_rob_id = '0; bus.rs_value = '0;
    bus.lsb_ready = 1'b0; bus.lsb_rob_id = '0; bus.lsb_value = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_rob_full", 32'(bus.rob_full), 32'd0);
    check("rst_tail_id", 32'(bus.tail_id), 32'd0);
    check("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("rst_rob_clear", 32'(bus.rob_clear), 32'd0);
    check("rst_clear_pc", bus.clear_pc, 32'd0);
    check("rst_query_ready", 32'(bus.query_ready1), 32'd0);

    // Fill all eight entries, then try a ninth.
    for (int i = 0; i < 8; i++) begin
      expect_commit(W'(i), 5'(i + 1), fill_val(i), 1'b1, 1'b0, 1'b0, 32'h0);
      issue(KReg, 5'(i + 1), 1'b0, 32'h0);
    end
    check("full_rob_full", 32'(bus.rob_full), 32'd1);
    check("full_tail_id", 32'(bus.tail_id), 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    check("ninth_tail_id", 32'(bus.tail_id), 32'd0);
    check("ninth_rob_full", 32'(bus.rob_full), 32'd1);

    // Younger entry ready first must not retire ahead of the head.
    bus.rs_ready = 1'b1; bus.rs_rob_id = W'(1); bus.rs_value = 32'h55;
    tick();
    bus.rs_ready = 1'b0; bus.query_id2 = W'(1);
    #1;
    check("stored_query_ready", 32'(bus.query_ready2), 32'd1);
    check("stored_query_value", bus.query_value2, 32'h55);
    tick();
    check("ooo_no_commit", 32'(bus.commit_valid), 32'd0);
    bus.rs_ready = 1'b1; bus.rs_rob_id = W'(0); bus.rs_value = 32'h11;
    tick();
    bus.rs_ready = 1'b0;
    check("wb_to_commit_latency", 32'(bus.commit_valid), 32'd0);
    tick();
    check("commit0_valid", 32'(bus.commit_valid), 32'd1);
    check("commit0_id", 32'(bus.commit_rob_id), 32'd0);
    check("commit0_unfull", 32'(bus.rob_full), 32'd0);
    tick();
    check("commit1_valid", 32'(bus.commit_valid), 32'd1);
    check("commit1_id", 32'(bus.commit_rob_id), 32'd1);

    // Same-cycle broadcast bypass on the query port; rs and lsb on different ids.
    bus.query_id1 = W'(3);
    #1;
    check("query3_before", 32'(bus.query_ready1), 32'd0);
    bus.rs_ready = 1'b1; bus.rs_rob_id = W'(3); bus.rs_value = 32'hDEAD;
    bus.lsb_ready = 1'b1; bus.lsb_rob_id = W'(2); bus.lsb_value = fill_val(2);
    #1;
    check("query3_bypass_ready", 32'(bus.query_ready1), 32'd1);
    check("query3_bypass_value", bus.query_value1, 32'hDEAD);
    tick();
    bus.rs_rob_id = W'(4); bus.rs_value = fill_val(4);
    bus.lsb_rob_id = W'(5); bus.lsb_value = fill_val(5);
    tick();
    bus.rs_rob_id = W'(6); bus.rs_value = fill_val(6);
    bus.lsb_rob_id = W'(7); bus.lsb_value = fill_val(7);
    tick();
    bus.rs_ready = 1'b0; bus.lsb_ready = 1'b0;
    wait_drain("fill_drain");

    // Vector table: one transaction at a time.
    for (int i = 0; i < 7; i++) begin
      logic [W-1:0] id;
      id = exp_tail;
      check("vec_tail_id", 32'(bus.tail_id), 32'(id));
      expect_commit(id, vecs[i].exp_rd, vecs[i].wb, vecs[i].kind != KNop, vecs[i].exp_store,
                    1'b0, 32'h0);
      issue(vecs[i].kind, vecs[i].rd, vecs[i].pred, vecs[i].alt_pc);
      if (vecs[i].kind != KNop) begin
        if (vecs[i].via_lsb) begin
          bus.lsb_ready = 1'b1; bus.lsb_rob_id = id; bus.lsb_value = vecs[i].wb;
        end else begin
          bus.rs_ready = 1'b1; bus.rs_rob_id = id; bus.rs_value = vecs[i].wb;
        end
        tick();
        bus.rs_ready = 1'b0; bus.lsb_ready = 1'b0;
      end
      wait_drain("vec_drain");
    end

    // Mispredict across the wrap point; the younger REG must be flushed.
    begin
      logic [W-1:0] br_id;
      int n;
      br_id = exp_tail;
      expect_commit(br_id, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h104);
      issue(KBr, 5'd0, 1'b1, 32'h104);
      issue(KReg, 5'd9, 1'b0, 32'h0);
      bus.rs_ready = 1'b1; bus.rs_rob_id = br_id; bus.rs_value = 32'h0;
      bus.lsb_ready = 1'b1; bus.lsb_rob_id = br_id + 1'b1; bus.lsb_value = 32'h99;
      tick();
      bus.rs_ready = 1'b0; bus.lsb_ready = 1'b0;
      n = 0;
      while (!bus.rob_clear && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("flush_seen", 32'(bus.rob_clear), 32'd1);
      // Issue during the flush cycle is discarded.
      bus.issue_valid = 1'b1; bus.issue_kind = KReg; bus.issue_rd = 5'd4;
      tick();
      bus.issue_valid = 1'b0;
      exp_tail = '0;
      check("flush_tail_id", 32'(bus.tail_id), 32'd0);
      check("flush_rob_full", 32'(bus.rob_full), 32'd0);
      check("flush_clear_drop", 32'(bus.rob_clear), 32'd0);
      check("flush_commit_valid", 32'(bus.commit_valid), 32'd0);
      repeat (3) tick();
      check("flush_sb_empty", 32'(sb.size()), 32'd0);
      check_perf("perf_flush");
    end

    // STORE retire, then rdy=0 holds outputs and blocks issue.
    expect_commit(exp_tail, 5'd0, 32'hCAFE, 1'b1, 1'b1, 1'b0, 32'h0);
    issue(KSt, 5'd7, 1'b0, 32'h0);
    bus.lsb_ready = 1'b1; bus.lsb_rob_id = '0; bus.lsb_value = 32'hCAFE;
    tick();
    bus.lsb_ready = 1'b0;
    tick();
    check("store_commit_valid", 32'(bus.commit_valid), 32'd1);
    bus.rdy = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_kind = KReg; bus.issue_rd = 5'd6;
    repeat (3) begin
      tick();
      check("stall_commit_valid", 32'(bus.commit_valid), 32'd1);
      check("stall_commit_store", 32'(bus.commit_store), 32'd1);
      check("stall_commit_rd", 32'(bus.commit_rd), 32'd0);
      check("stall_commit_value", bus.commit_value, 32'hCAFE);
      check("stall_tail_id", 32'(bus.tail_id), 32'(exp_tail));
    end
    bus.issue_valid = 1'b0;
    bus.rdy = 1'b1;
    tick();
    check("unstall_commit_valid", 32'(bus.commit_valid), 32'd0);

    // Reset with five entries in flight.
    for (int i = 0; i < 5; i++) issue(KReg, 5'(10 + i), 1'b0, 32'h0);
    check("inflight_tail_id", 32'(bus.tail_id), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_tail = '0;
    bus.query_id1 = '0;
    #1;
    check("midrst_rob_full", 32'(bus.rob_full), 32'd0);
    check("midrst_tail_id", 32'(bus.tail_id), 32'd0);
    check("midrst_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("midrst_query_ready", 32'(bus.query_ready1), 32'd0);
    bus.lsb_ready = 1'b1; bus.lsb_rob_id = '0; bus.lsb_value = 32'h33;
    tick();
    bus.lsb_ready = 1'b0;
    repeat (3) tick();

    expect_commit(exp_tail, 5'd2, 32'hABC, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(KReg, 5'd2, 1'b0, 32'h0);
    bus.rs_ready = 1'b1; bus.rs_rob_id = '0; bus.rs_value = 32'hABC;
    tick();
    bus.rs_ready = 1'b0;
    wait_drain("post_rst_drain");
    tick();
    check_perf("perf_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
